// File: rtl/huff_dht_loader_pkg.sv
// Shared encodings for the DHT segment loader: sampling modes, FSM states,
// error codes and Huffman table indices.
package huff_dht_loader_pkg;

  localparam logic [1:0] SAMP_444  = 2'd0;
  localparam logic [1:0] SAMP_422  = 2'd1;
  localparam logic [1:0] SAMP_420  = 2'd2;
  localparam logic [1:0] SAMP_GRAY = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_MAP, S_LEN_HI, S_LEN_LO, S_TCTH,
    S_BITS, S_PAD, S_VALS, S_DONE, S_ERR
  } state_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_SHORT_LH = 3'd1;
  localparam logic [2:0] ERR_TCTH     = 3'd2;
  localparam logic [2:0] ERR_ORDER    = 3'd3;
  localparam logic [2:0] ERR_COUNT    = 3'd4;
  localparam logic [2:0] ERR_VAL_OVF  = 3'd5;
  localparam logic [2:0] ERR_TRUNC    = 3'd6;

  localparam logic [1:0] IDX_DC0 = 2'd0;
  localparam logic [1:0] IDX_DC1 = 2'd1;
  localparam logic [1:0] IDX_AC0 = 2'd2;
  localparam logic [1:0] IDX_AC1 = 2'd3;

  // Smallest legal Lh: the length field itself, Tc/Th and 16 code counts.
  localparam int unsigned MIN_LH = 19;

endpackage

// File: rtl/huff_dht_counter.sv
// Byte/length bookkeeping for the DHT loader: remaining segment bytes, the
// per-table code count and the running value total, plus their limit compares.
module huff_dht_counter
  import huff_dht_loader_pkg::*;
#(
  parameter int CODE_AW = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_all,
  input  logic        load_len,
  input  logic [15:0] len,
  input  logic        byte_acc,
  input  logic        sum_clr,
  input  logic        sum_add,
  input  logic [7:0]  sum_byte,
  input  logic        val_acc,
  output logic        len_short,
  output logic        last_byte,
  output logic        left_zero,
  output logic        sum_zero,
  output logic        sum_last,
  output logic        sum_too_big,
  output logic        val_ovf
);

  logic [15:0]      bytes_left_q, bytes_left_d;
  logic [8:0]       count_sum_q, count_sum_d;
  logic [CODE_AW:0] value_count_q, value_count_d;
  logic [9:0]       sum_ext;
  logic [31:0]      val_total;

  // count_sum saturates so a huge BITS total can never wrap back under 256.
  always_comb begin
    bytes_left_d  = bytes_left_q;
    count_sum_d   = count_sum_q;
    value_count_d = value_count_q;
    sum_ext       = {1'b0, count_sum_q} + {2'b00, sum_byte};
    if (clr_all) begin
      bytes_left_d  = '0;
      count_sum_d   = '0;
      value_count_d = '0;
    end else begin
      if (load_len)
        bytes_left_d = len - 16'd2;
      else if (byte_acc)
        bytes_left_d = bytes_left_q - 16'd1;
      if (sum_clr)
        count_sum_d = '0;
      else if (sum_add)
        count_sum_d = sum_ext[9] ? 9'h1FF : sum_ext[8:0];
      else if (val_acc)
        count_sum_d = count_sum_q - 9'd1;
      if (val_acc)
        value_count_d = value_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_left_q  <= '0;
      count_sum_q   <= '0;
      value_count_q <= '0;
    end else begin
      bytes_left_q  <= bytes_left_d;
      count_sum_q   <= count_sum_d;
      value_count_q <= value_count_d;
    end
  end

  assign val_total   = 32'(value_count_q) + 32'(count_sum_q);
  assign len_short   = len < 16'(MIN_LH);
  assign last_byte   = bytes_left_q == 16'd1;
  assign left_zero   = bytes_left_q == 16'd0;
  assign sum_zero    = count_sum_q == 9'd0;
  assign sum_last    = count_sum_q == 9'd1;
  assign sum_too_big = count_sum_q > 9'd256;
  assign val_ovf     = val_total > (32'd1 << CODE_AW);

endmodule

// File: rtl/huff_dht_loader.sv
// DHT segment parser that replays Huffman tables as decoder write beats and
// reports done/error to the frame-header controller.
module huff_dht_loader
  import huff_dht_loader_pkg::*;
#(
  parameter int CODE_AW = 12,
  parameter int NUM_TB  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic [1:0]        map_mode,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg,
  output logic              wr,
  output logic              wr_sel,
  output logic [7:0]        wr_huff_tb,
  output logic [1:0]        wr_map_mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [NUM_TB-1:0] tables_loaded
);

  localparam int IW = $clog2(NUM_TB + 1);

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [1:0]        tbl_idx_q, tbl_idx_d;
  logic [IW-1:0]     exp_idx_q, exp_idx_d;
  logic [NUM_TB-1:0] tables_loaded_q, tables_loaded_d;
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        err_code_q, err_code_d;
  logic              cfg_q, cfg_d;
  logic              wr_q, wr_d, wr_sel_q, wr_sel_d;
  logic [7:0]        wr_tb_q, wr_tb_d;
  logic [1:0]        wr_map_q, wr_map_d;

  logic accept, clr_all, load_len, byte_acc, sum_clr, sum_add, val_acc;
  logic len_short, last_byte, left_zero, sum_zero, sum_last, sum_too_big, val_ovf;
  logic [1:0] in_idx;

  assign in_ready = state_q inside {S_LEN_HI, S_LEN_LO, S_TCTH, S_BITS, S_VALS};
  assign accept   = in_valid & in_ready;
  assign in_idx   = {in_data[4], in_data[0]};

  huff_dht_counter #(.CODE_AW(CODE_AW)) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_all     (clr_all),
    .load_len    (load_len),
    .len         ({len_hi_q, in_data}),
    .byte_acc    (byte_acc),
    .sum_clr     (sum_clr),
    .sum_add     (sum_add),
    .sum_byte    (in_data),
    .val_acc     (val_acc),
    .len_short   (len_short),
    .last_byte   (last_byte),
    .left_zero   (left_zero),
    .sum_zero    (sum_zero),
    .sum_last    (sum_last),
    .sum_too_big (sum_too_big),
    .val_ovf     (val_ovf)
  );

  // A byte that triggers an error is never forwarded to the decoder.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    len_hi_d        = len_hi_q;
    tbl_idx_d       = tbl_idx_q;
    exp_idx_d       = exp_idx_q;
    tables_loaded_d = tables_loaded_q;
    mode_d          = mode_q;
    err_code_d      = err_code_q;
    wr_map_d        = wr_map_q;
    wr_d            = 1'b0;
    wr_sel_d        = 1'b0;
    wr_tb_d         = 8'h00;
    clr_all         = 1'b0;
    load_len        = 1'b0;
    byte_acc        = 1'b0;
    sum_clr         = 1'b0;
    sum_add         = 1'b0;
    val_acc         = 1'b0;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d    = S_MAP;
          mode_d     = map_mode;
          err_code_d = ERR_NONE;
        end
      end
      S_MAP: begin
        wr_sel_d = 1'b1;
        wr_map_d = mode_q;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          load_len = 1'b1;
          if (len_short) begin
            state_d    = S_ERR;
            err_code_d = ERR_SHORT_LH;
          end else begin
            state_d = S_TCTH;
          end
        end
      end
      S_TCTH: begin
        if (accept) begin
          byte_acc = 1'b1;
          if (in_data[7:4] > 4'd1 || in_data[3:0] > 4'd1) begin
            state_d    = S_ERR;
            err_code_d = ERR_TCTH;
          end else if (IW'(in_idx) != exp_idx_q) begin
            state_d    = S_ERR;
            err_code_d = ERR_ORDER;
          end else if (last_byte) begin
            state_d    = S_ERR;
            err_code_d = ERR_TRUNC;
          end else begin
            tbl_idx_d = in_idx;
            sum_clr   = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = S_BITS;
          end
        end
      end
      S_BITS: begin
        if (accept) begin
          byte_acc = 1'b1;
          if (last_byte && bit_cnt_q != 4'd15) begin
            state_d    = S_ERR;
            err_code_d = ERR_TRUNC;
          end else begin
            wr_d      = 1'b1;
            wr_tb_d   = in_data;
            sum_add   = 1'b1;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15)
              state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (sum_too_big) begin
          state_d    = S_ERR;
          err_code_d = ERR_COUNT;
        end else if (val_ovf) begin
          state_d    = S_ERR;
          err_code_d = ERR_VAL_OVF;
        end else if (!sum_zero && left_zero) begin
          state_d    = S_ERR;
          err_code_d = ERR_TRUNC;
        end else begin
          wr_d = 1'b1;
          if (sum_zero) begin
            tables_loaded_d[tbl_idx_q] = 1'b1;
            if (exp_idx_q != IW'(NUM_TB))
              exp_idx_d = exp_idx_q + IW'(1);
            state_d = left_zero ? S_DONE : S_TCTH;
          end else begin
            state_d = S_VALS;
          end
        end
      end
      S_VALS: begin
        if (accept) begin
          byte_acc = 1'b1;
          if (last_byte && !sum_last) begin
            state_d    = S_ERR;
            err_code_d = ERR_TRUNC;
          end else begin
            wr_d     = 1'b1;
            wr_sel_d = 1'b1;
            wr_tb_d  = in_data;
            val_acc  = 1'b1;
            if (sum_last) begin
              tables_loaded_d[tbl_idx_q] = 1'b1;
              if (exp_idx_q != IW'(NUM_TB))
                exp_idx_d = exp_idx_q + IW'(1);
              state_d = last_byte ? S_DONE : S_TCTH;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // clr beats everything, including a start in the same cycle.
    if (clr) begin
      state_d         = S_IDLE;
      exp_idx_d       = '0;
      tables_loaded_d = '0;
      err_code_d      = ERR_NONE;
      wr_d            = 1'b0;
      wr_sel_d        = 1'b0;
      wr_tb_d         = 8'h00;
      clr_all         = 1'b1;
    end

    cfg_d = state_d inside {S_MAP, S_LEN_HI, S_LEN_LO, S_TCTH, S_BITS, S_PAD, S_VALS};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      bit_cnt_q       <= '0;
      len_hi_q        <= '0;
      tbl_idx_q       <= '0;
      exp_idx_q       <= '0;
      tables_loaded_q <= '0;
      mode_q          <= '0;
      err_code_q      <= ERR_NONE;
      cfg_q           <= 1'b0;
      wr_q            <= 1'b0;
      wr_sel_q        <= 1'b0;
      wr_tb_q         <= '0;
      wr_map_q        <= '0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      len_hi_q        <= len_hi_d;
      tbl_idx_q       <= tbl_idx_d;
      exp_idx_q       <= exp_idx_d;
      tables_loaded_q <= tables_loaded_d;
      mode_q          <= mode_d;
      err_code_q      <= err_code_d;
      cfg_q           <= cfg_d;
      wr_q            <= wr_d;
      wr_sel_q        <= wr_sel_d;
      wr_tb_q         <= wr_tb_d;
      wr_map_q        <= wr_map_d;
    end
  end

  assign cfg           = cfg_q;
  assign wr            = wr_q;
  assign wr_sel        = wr_sel_q;
  assign wr_huff_tb    = wr_tb_q;
  assign wr_map_mode   = wr_map_q;
  assign busy          = state_q inside {S_MAP, S_LEN_HI, S_LEN_LO, S_TCTH, S_BITS, S_PAD, S_VALS};
  assign done          = state_q == S_DONE;
  assign err           = state_q == S_ERR;
  assign err_code      = err_code_q;
  assign tables_loaded = tables_loaded_q;

endmodule

// File: tb/tb_huff_dht_loader.sv
// Directed and randomized DHT segments checked against a byte-level parse
// model of the segment that predicts every decoder beat and the final status.
module tb_huff_dht_loader;
  import huff_dht_loader_pkg::*;

  logic       clk, rst_n, clr, start, in_valid, in_ready;
  logic [1:0] map_mode, wr_map_mode;
  logic [7:0] in_data, wr_huff_tb;
  logic       cfg, wr, wr_sel, busy, done, err;
  logic [2:0] err_code;
  logic [3:0] tables_loaded;

  huff_dht_loader #(.CODE_AW(12), .NUM_TB(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .start         (start),
    .map_mode      (map_mode),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .cfg           (cfg),
    .wr            (wr),
    .wr_sel        (wr_sel),
    .wr_huff_tb    (wr_huff_tb),
    .wr_map_mode   (wr_map_mode),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_code      (err_code),
    .tables_loaded (tables_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0]  seg[$];
  logic [7:0]  body[$];
  logic [11:0] beats[$];
  logic [11:0] exp_beats[$];

  int         m_exp;
  int         m_vc;
  logic [3:0] m_tl;
  int         m_code;

  logic [7:0] dc_cnt [16];
  logic [7:0] ac_cnt [16];
  logic [7:0] c3_cnt [16];
  logic [7:0] c300_cnt [16];

  // Beat record: {wr, wr_sel, data, map mode (only meaningful for the map write)}
  always @(negedge clk)
    if (rst_n && (wr || wr_sel))
      beats.push_back({wr, wr_sel, wr_huff_tb, (wr ? 2'b00 : wr_map_mode)});

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] tcth_of(input logic [1:0] idx);
    return {3'b000, idx[1], 3'b000, idx[0]};
  endfunction

  function automatic void model_reset();
    m_exp = 0;
    m_vc  = 0;
    m_tl  = 4'b0000;
  endfunction

  function automatic void push_table(input logic [7:0] tcth, input logic [7:0] cnt [16],
                                     input int drop);
    int sum;
    sum = 0;
    body.push_back(tcth);
    for (int i = 0; i < 16; i++) begin
      body.push_back(cnt[i]);
      sum += int'(cnt[i]);
    end
    for (int j = 0; j < sum - drop; j++)
      body.push_back(8'($urandom_range(0, 255)));
  endfunction

  function automatic void make_seg(input int lh_override);
    int lh;
    seg.delete();
    lh = (lh_override >= 0) ? lh_override : body.size() + 2;
    seg.push_back(8'(lh >> 8));
    seg.push_back(8'(lh));
    foreach (body[i]) seg.push_back(body[i]);
    body.delete();
  endfunction

  // Walks the segment bytes the way the DHT format defines them and lists the
  // decoder beats that must appear, stopping at the first rule violation.
  function automatic void run_model(input logic [1:0] mode);
    int lh, pos, sum, idx;
    logic [7:0] b;
    exp_beats.delete();
    exp_beats.push_back({1'b0, 1'b1, 8'h00, mode});
    lh = int'({seg[0], seg[1]});
    if (lh < 19) begin m_code = 1; return; end
    pos = 2;
    while (1'b1) begin
      b = seg[pos]; pos++;
      if (b[7:4] > 4'd1 || b[3:0] > 4'd1) begin m_code = 2; return; end
      idx = int'({b[4], b[0]});
      if (idx != m_exp) begin m_code = 3; return; end
      if (pos == lh) begin m_code = 6; return; end
      sum = 0;
      for (int i = 0; i < 16; i++) begin
        b = seg[pos]; pos++;
        if (pos == lh && i < 15) begin m_code = 6; return; end
        exp_beats.push_back({2'b10, b, 2'b00});
        sum += int'(b);
      end
      if (sum > 256) begin m_code = 4; return; end
      if (m_vc + sum > 4096) begin m_code = 5; return; end
      if (sum > 0 && pos == lh) begin m_code = 6; return; end
      exp_beats.push_back({2'b10, 8'h00, 2'b00});
      for (int j = 0; j < sum; j++) begin
        b = seg[pos]; pos++;
        if (pos == lh && j < sum - 1) begin m_code = 6; return; end
        exp_beats.push_back({2'b11, b, 2'b00});
        m_vc++;
      end
      m_tl[idx] = 1'b1;
      if (m_exp < 4) m_exp++;
      if (pos == lh) begin m_code = 0; return; end
    end
  endfunction

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_reset();
  endtask

  // vmode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random valid
  task automatic run_seg(input string name, input logic [1:0] mode, input int vmode,
                         input int abort_at);
    int idx, cyc, obs_code;
    bit acc, saw_done, saw_err;
    logic [2:0] saw_code;
    idx = 0; cyc = 0; saw_done = 0; saw_err = 0; saw_code = 3'd0;
    beats.delete();
    run_model(mode);
    map_mode = mode;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({name, "_cfg_on"}, 32'(cfg), 32'd1);
    check({name, "_busy_on"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    while (!(saw_done || saw_err) && cyc < 4000) begin
      in_valid = (idx < seg.size()) &&
                 (vmode == 0 || (vmode == 1 && cyc[0]) || (vmode == 2 && $urandom_range(0, 1) == 1));
      in_data  = (idx < seg.size()) ? seg[idx] : 8'h00;
      @(negedge clk);
      acc      = in_valid && in_ready;
      saw_done = done;
      saw_err  = err;
      saw_code = err_code;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
      if (abort_at >= 0 && beats.size() >= abort_at) break;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    if (abort_at >= 0) begin
      rst_n = 1'b0;
      #1;
      check({name, "_rst_wr"}, 32'(wr), 32'd0);
      check({name, "_rst_wr_sel"}, 32'(wr_sel), 32'd0);
      check({name, "_rst_tb"}, 32'(wr_huff_tb), 32'd0);
      check({name, "_rst_map"}, 32'(wr_map_mode), 32'd0);
      check({name, "_rst_cfg"}, 32'(cfg), 32'd0);
      check({name, "_rst_busy"}, 32'(busy), 32'd0);
      check({name, "_rst_ready"}, 32'(in_ready), 32'd0);
      check({name, "_rst_loaded"}, 32'(tables_loaded), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      return;
    end
    repeat (2) @(posedge clk);
    #1;
    obs_code = saw_done ? 0 : (saw_err ? int'(saw_code) : 7);
    check({name, "_status"}, 32'(obs_code), 32'(m_code));
    check({name, "_nbeats"}, 32'(beats.size()), 32'(exp_beats.size()));
    for (int i = 0; i < beats.size() && i < exp_beats.size(); i++)
      check($sformatf("%s_beat%0d", name, i), 32'(beats[i]), 32'(exp_beats[i]));
    check({name, "_loaded"}, 32'(tables_loaded), 32'(m_tl));
    check({name, "_cfg_off"}, 32'(cfg), 32'd0);
    check({name, "_err_hold"}, 32'(err), 32'(m_code != 0));
  endtask

  initial begin
    logic [7:0] rc [16];
    int ntab, drop;
    dc_cnt   = '{8'd0, 8'd1, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ac_cnt   = '{8'd0, 8'd2, 8'd1, 8'd3, 8'd3, 8'd2, 8'd4, 8'd3,
                 8'd5, 8'd5, 8'd4, 8'd4, 8'd0, 8'd0, 8'd1, 8'h7d};
    c3_cnt   = '{8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    c300_cnt = '{8'd255, 8'd45, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; map_mode = 2'b00;
    in_data = 8'h00; in_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_cfg", 32'(cfg), 32'd0);
    check("reset_wr", 32'(wr), 32'd0);
    check("reset_wr_sel", 32'(wr_sel), 32'd0);
    check("reset_tb", 32'(wr_huff_tb), 32'd0);
    check("reset_map", 32'(wr_map_mode), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_err_code", 32'(err_code), 32'd0);
    check("reset_loaded", 32'(tables_loaded), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single DC0 table, 4:2:0");
    push_table(tcth_of(IDX_DC0), dc_cnt, 0);
    make_seg(-1);
    run_seg("dc0", SAMP_420, 0, -1);

    $display("[TB] four standard tables in one segment");
    do_clr();
    push_table(tcth_of(IDX_DC0), dc_cnt, 0);
    push_table(tcth_of(IDX_DC1), dc_cnt, 0);
    push_table(tcth_of(IDX_AC0), ac_cnt, 0);
    push_table(tcth_of(IDX_AC1), ac_cnt, 0);
    make_seg(-1);
    run_seg("std4", SAMP_444, 0, -1);

    $display("[TB] fifth table after all four loaded");
    push_table(tcth_of(IDX_DC0), dc_cnt, 0);
    make_seg(-1);
    run_seg("sat", SAMP_422, 0, -1);

    $display("[TB] four tables in separate stalled segments");
    do_clr();
    for (int t = 0; t < 4; t++) begin
      push_table(tcth_of(2'(t)), (t < 2) ? dc_cnt : ac_cnt, 0);
      make_seg(-1);
      run_seg($sformatf("sep%0d", t), 2'(t), 1, -1);
    end

    $display("[TB] AC0 first after clr");
    do_clr();
    push_table(tcth_of(IDX_AC0), ac_cnt, 0);
    make_seg(-1);
    run_seg("order", SAMP_420, 0, -1);

    $display("[TB] illegal Tc");
    do_clr();
    push_table(8'h20, dc_cnt, 0);
    make_seg(-1);
    run_seg("tcth", SAMP_420, 0, -1);

    $display("[TB] short Lh");
    push_table(tcth_of(IDX_DC0), dc_cnt, 0);
    make_seg(16);
    run_seg("shortlh", SAMP_420, 0, -1);

    $display("[TB] segment ends inside values");
    do_clr();
    push_table(tcth_of(IDX_DC0), c3_cnt, 1);
    make_seg(-1);
    run_seg("trunc", SAMP_420, 0, -1);

    $display("[TB] code counts totalling 300");
    do_clr();
    push_table(tcth_of(IDX_DC0), c300_cnt, 300);
    make_seg(-1);
    run_seg("cnt300", SAMP_420, 0, -1);

    $display("[TB] randomized segments");
    for (int r = 0; r < 5; r++) begin
      do_clr();
      ntab = $urandom_range(1, 4);
      for (int t = 0; t < ntab; t++) begin
        for (int k = 0; k < 16; k++) rc[k] = 8'($urandom_range(0, 3));
        drop = (t == ntab - 1 && $urandom_range(0, 3) == 0) ? 1 : 0;
        push_table(tcth_of(2'(t)), rc, drop);
      end
      make_seg(-1);
      run_seg($sformatf("rnd%0d", r), 2'($urandom_range(0, 3)), 2, -1);
    end

    $display("[TB] reset during values");
    do_clr();
    push_table(tcth_of(IDX_DC0), dc_cnt, 0);
    make_seg(-1);
    run_seg("rstmid", SAMP_GRAY, 0, 20);
    push_table(tcth_of(IDX_DC0), dc_cnt, 0);
    make_seg(-1);
    run_seg("after_rst", SAMP_420, 2, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
